mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing the single-ported main grid memory bank among NUM_REQ requesters, e.g. the staging loader (req 0) and the core's row scanner/updater (req 1).
- Each requester issues one read or write transaction at a time over a req/ack handshake.
- The arbiter registers the winning transaction, drives the bank port, waits for the bank's ack and returns an ack pulse plus read data to the winner.
- Sits in top between the requesters and the bank; the top-level mem_ack_out / mem_busy_out are derived from its per-requester outputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BANK_ADDR_WIDTH, 8, row address width.
- COL_ADDR_WIDTH, 8, column address width.
- TX_DATA_WIDTH, 32, partial row vector width.
- TIMEOUT_CYCLES, 64, bank-ack watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; asserted at 0.
- req_in  in  NUM_REQ  per-requester request level.
- req_we_in  in  NUM_REQ  1 = write, 0 = read.
- req_row_in  in  NUM_REQ*BANK_ADDR_WIDTH  packed row addresses; requester i in slice i.
- req_col_in  in  NUM_REQ*COL_ADDR_WIDTH  packed column addresses.
- req_wdata_in  in  NUM_REQ*TX_DATA_WIDTH  packed write vectors.
- ack_out  out  NUM_REQ  one-cycle completion pulse to the winner.
- busy_out  out  NUM_REQ  high from grant until the ack cycle, inclusive.
- rdata_out  out  TX_DATA_WIDTH  read data; valid in the ack cycle.
- timeout_out  out  1  transaction aborted by the watchdog; valid with ack.
- grant_id_out  out  $clog2(NUM_REQ)  index of the current or last winner.
- mem_req_out  out  1  bank request; held until mem_ack_in.
- mem_we_out  out  1  bank write enable.
- mem_row_out  out  BANK_ADDR_WIDTH  bank row address.
- mem_col_out  out  COL_ADDR_WIDTH  bank column address.
- mem_wdata_out  out  TX_DATA_WIDTH  bank write vector.
- mem_ack_in  in  1  one-cycle pulse from the bank: transaction done.
- mem_rdata_in  in  TX_DATA_WIDTH  bank read data; valid with mem_ack_in.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; all outputs go to 0.
  - Round-robin pointer last goes to NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction drops mem_req_out immediately; no ack is issued for the aborted transaction.
- FSM states: IDLE -> MEM -> DONE -> IDLE.
- IDLE:
  - If any req_in is set, the winner is the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Registered into the output stage: winner's we/row/col/wdata, grant_id_out = winner, busy_out[winner]=1, last = winner.
  - Next state MEM; mem_req_out=1 from the next cycle.
  - mem_ack_in is ignored in IDLE; stray acks after a reset are discarded.
- MEM:
  - mem_* outputs hold stable.
  - When mem_ack_in=1: capture mem_rdata_in into rdata_out, go to DONE.
  - mem_req_out deasserts in the cycle after mem_ack_in.
- DONE:
  - ack_out[grant_id]=1 for exactly one cycle; busy_out[grant_id] stays 1 this cycle and drops after it.
  - rdata_out is valid; write transactions leave rdata_out unchanged.
  - req_in is not sampled; the requester must deassert or present a new transaction during the ack cycle.
- Latency: req seen at edge t -> mem_req_out at t+1; bank ack at cycle t+k -> ack_out at t+k+1. Minimum 3 cycles with a 1-cycle bank.
- Back-to-back requests earliest at t+k+2.
- Fairness: with all requesters asserting continuously, grants rotate strictly 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
- Requester-side violations:
  - A requester dropping req_in while granted does not cancel the transaction; its ack is still pulsed.
  - Request fields changing after grant are ignored, since they were captured at grant.
- Only one bit of ack_out / busy_out is ever high.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in MEM and clears on entering MEM.
  - If it reaches TIMEOUT_CYCLES without mem_ack_in: drop mem_req_out, go to DONE, pulse ack_out with timeout_out=1 and rdata_out=0.
  - timeout_out clears in the next transaction's grant cycle.
  - If mem_ack_in arrives in the same cycle the limit is hit, the ack wins and timeout_out=0.
- When not defined: no counter; MEM waits indefinitely; timeout_out is tied to 0.

Test Plan:
- Reset, then req_in=01, write, row 3, col 0, wdata 0xA5A5_0F0F, bank acks 1 cycle after mem_req_out -> mem_* show row 3 / col 0 / we=1; ack_out=01 exactly 3 cycles after req; then a read of the same address returns rdata_out 0xA5A5_0F0F.
- req_in=11 held, every transaction a read -> grant order 0,1,0,1; grant_id_out alternates; each ack_out is a single-cycle pulse; busy_out is never 11.
- Bank delays its ack 10 cycles -> mem_req_out and row/col/wdata stay stable all 10 cycles; ack_out 1 cycle after mem_ack_in.
- Assert reset (0) mid-MEM, then pulse mem_ack_in after release -> all outputs 0; stray ack ignored; no ack_out pulse; next grant goes to requester 0.
- Requester 1 changes req_row_in from 5 to 9 one cycle after grant -> mem_row_out stays 5.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, bank never acks -> ack_out plus timeout_out=1 at cycle 64 of MEM; rdata_out=0. Without the macro, no ack occurs within 200 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported grid memory bank among requesters.
// Optional bank-ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int COL_ADDR_WIDTH  = 8,
    parameter int TX_DATA_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_in,
    input  logic [NUM_REQ-1:0]                 req_we_in,
    input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0] req_row_in,
    input  logic [NUM_REQ*COL_ADDR_WIDTH-1:0]  req_col_in,
    input  logic [NUM_REQ*TX_DATA_WIDTH-1:0]   req_wdata_in,
    output logic [NUM_REQ-1:0]                 ack_out,
    output logic [NUM_REQ-1:0]                 busy_out,
    output logic [TX_DATA_WIDTH-1:0]           rdata_out,
    output logic                               timeout_out,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id_out,
    output logic                               mem_req_out,
    output logic                               mem_we_out,
    output logic [BANK_ADDR_WIDTH-1:0]         mem_row_out,
    output logic [COL_ADDR_WIDTH-1:0]          mem_col_out,
    output logic [TX_DATA_WIDTH-1:0]           mem_wdata_out,
    input  logic                               mem_ack_in,
    input  logic [TX_DATA_WIDTH-1:0]           mem_rdata_in
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   win;
    logic             found;
    int               idx;
    logic             grant_en;
    logic             finish_en;
    logic             timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt;

    // Watchdog: counts cycles spent waiting for the bank, restarted at grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (grant_en) begin
            to_cnt <= '0;
        end else if (state == MEM) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == MEM) && !mem_ack_in &&
                         (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin search: first set request after the last winner.
    always_comb begin
        win   = last;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && req_in[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the grant / completion strobes.
    always_comb begin
        state_nx  = state;
        grant_en  = 1'b0;
        finish_en = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_en = 1'b1;
                    state_nx = MEM;
                end
            end
            MEM: begin
                if (mem_ack_in || timeout_hit) begin
                    finish_en = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output stage: capture the winner at grant, complete on bank ack or watchdog.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_out       <= '0;
            busy_out      <= '0;
            rdata_out     <= '0;
            timeout_out   <= 1'b0;
            grant_id_out  <= '0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_row_out   <= '0;
            mem_col_out   <= '0;
            mem_wdata_out <= '0;
            last          <= IDW'(NUM_REQ - 1);
        end else begin
            ack_out <= '0;
            if (grant_en) begin
                mem_req_out   <= 1'b1;
                mem_we_out    <= req_we_in[win];
                mem_row_out   <= req_row_in[int'(win)*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
                mem_col_out   <= req_col_in[int'(win)*COL_ADDR_WIDTH +: COL_ADDR_WIDTH];
                mem_wdata_out <= req_wdata_in[int'(win)*TX_DATA_WIDTH +: TX_DATA_WIDTH];
                grant_id_out  <= win;
                busy_out      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                last          <= win;
                timeout_out   <= 1'b0;
            end
            if (finish_en) begin
                mem_req_out <= 1'b0;
                ack_out     <= busy_out;
                if (!mem_ack_in) begin
                    rdata_out   <= '0;
                    timeout_out <= 1'b1;
                end else if (!mem_we_out) begin
                    rdata_out <= mem_rdata_in;
                end
            end
            if (state == DONE) begin
                busy_out <= '0;
            end
        end
    end

endmodule
